// File: rtl/frontend_request_translator.sv
// rtl/frontend_request_translator.sv - frontend request to ordered bank command translator with open-page row table
`ifndef ROW_ADDR_BITS
`define ROW_ADDR_BITS 14
`endif
`ifndef COL_ADDR_BITS
`define COL_ADDR_BITS 10
`endif

package frontend_request_translator_pkg;
    localparam int ROW_W = `ROW_ADDR_BITS;
    localparam int COL_W = `COL_ADDR_BITS;

    typedef enum logic [0:0] {OP_READ = 1'b0, OP_WRITE = 1'b1} op_type_t;
    typedef enum logic [1:0] {DT_BYTE, DT_HALF, DT_WORD, DT_DWORD} data_type_t;
    typedef enum logic [2:0] {
        CMD_NOP       = 3'd0,
        CMD_ACTIVE    = 3'd1,
        CMD_PRECHARGE = 3'd2,
        CMD_READ      = 3'd3,
        CMD_WRITE     = 3'd4
    } cmd_t;
    typedef enum logic [1:0] {BL_NONE = 2'd0, BL_4 = 2'd1, BL_8 = 2'd2} burst_length_t;

    typedef struct packed {
        op_type_t         op_type;
        data_type_t       data_type;
        logic [ROW_W-1:0] row_addr;
        logic [COL_W-1:0] col_addr;
        logic [2:0]       bank_addr;
        logic [4:0]       req_id;
        logic [1:0]       core_num;
    } frontend_interconnection_request_t;

    typedef struct packed {
        cmd_t          cmd;
        burst_length_t burst_length;
        logic [13:0]   row_addr;
        logic [13:0]   col_addr;
        logic [2:0]    bank_addr;
    } bank_command_t;
endpackage

module frontend_request_translator
    import frontend_request_translator_pkg::*;
#(
    parameter int NUM_BANKS = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  frontend_interconnection_request_t req_in,
    input  logic                              flush,
    output logic                              flush_done,
    output logic                              cmd_valid,
    input  logic                              cmd_ready,
    output bank_command_t                     cmd_out,
    output logic [6:0]                        cmd_tag,
    output logic                              cmd_last
);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_ACT, S_COL, S_FLUSH} state_t;

    state_t state, state_n;
    logic [2:0] idx, idx_n, nxt;
    op_type_t op_q, op_n;
    logic [ROW_W-1:0] row_q, row_n;
    logic [COL_W-1:0] col_q, col_n;
    logic [2:0] bank_q, bank_n;
    logic [NUM_BANKS-1:0] open_q, open_n;
    logic [NUM_BANKS-1:0][ROW_W-1:0] rows_q, rows_n;
    logic valid_n, last_n, done_n;
    bank_command_t out_n;
    logic [6:0] tag_n;

    // Data type does not influence the command stream.
    logic unused_data_type;
    assign unused_data_type = ^req_in.data_type;

    function automatic bank_command_t mk_cmd(cmd_t c, logic [ROW_W-1:0] row,
                                             logic [COL_W-1:0] col, logic [2:0] bank);
        bank_command_t r;
        r.cmd          = c;
        r.burst_length = BL_8;
        r.row_addr     = 14'(row);
        r.col_addr     = 14'(col);
        r.bank_addr    = bank;
        return r;
    endfunction

    function automatic cmd_t col_cmd(op_type_t op);
        return (op == OP_READ) ? CMD_READ : CMD_WRITE;
    endfunction

    assign req_ready = (state == S_IDLE) && !flush;

    // Output registers are loaded with the next command on the transition into
    // each emitting state, so the command is valid the cycle the state is entered.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        op_n    = op_q;
        row_n   = row_q;
        col_n   = col_q;
        bank_n  = bank_q;
        open_n  = open_q;
        rows_n  = rows_q;
        valid_n = cmd_valid;
        out_n   = cmd_out;
        tag_n   = cmd_tag;
        last_n  = cmd_last;
        done_n  = 1'b0;
        nxt     = idx + 3'd1;
        case (state)
            S_IDLE: begin
                if (flush) begin
                    state_n = S_FLUSH;
                    idx_n   = 3'd0;
                    tag_n   = 7'd0;
                    valid_n = open_q[0];
                    if (open_q[0]) out_n = mk_cmd(CMD_PRECHARGE, rows_q[0], '0, 3'd0);
                    else           out_n = '0;
                end else if (req_valid) begin
                    op_n    = req_in.op_type;
                    row_n   = req_in.row_addr;
                    col_n   = req_in.col_addr;
                    bank_n  = req_in.bank_addr;
                    tag_n   = {req_in.req_id, req_in.core_num};
                    valid_n = 1'b1;
                    if (open_q[req_in.bank_addr]) begin
                        if (rows_q[req_in.bank_addr] == req_in.row_addr) begin
                            state_n = S_COL;
                            last_n  = 1'b1;
                            out_n   = mk_cmd(col_cmd(req_in.op_type), req_in.row_addr,
                                             req_in.col_addr, req_in.bank_addr);
                        end else begin
                            state_n = S_PRE;
                            out_n   = mk_cmd(CMD_PRECHARGE, rows_q[req_in.bank_addr], '0,
                                             req_in.bank_addr);
                        end
                    end else begin
                        state_n = S_ACT;
                        out_n   = mk_cmd(CMD_ACTIVE, req_in.row_addr, '0, req_in.bank_addr);
                    end
                end
            end
            S_PRE: begin
                if (cmd_ready) begin
                    open_n[bank_q] = 1'b0;
                    state_n        = S_ACT;
                    out_n          = mk_cmd(CMD_ACTIVE, row_q, '0, bank_q);
                end
            end
            S_ACT: begin
                if (cmd_ready) begin
                    open_n[bank_q] = 1'b1;
                    rows_n[bank_q] = row_q;
                    state_n        = S_COL;
                    last_n         = 1'b1;
                    out_n          = mk_cmd(col_cmd(op_q), row_q, col_q, bank_q);
                end
            end
            S_COL: begin
                if (cmd_ready) begin
                    state_n = S_IDLE;
                    valid_n = 1'b0;
                    out_n   = '0;
                    tag_n   = 7'd0;
                    last_n  = 1'b0;
                end
            end
            S_FLUSH: begin
                // Closed banks carry no command, so they advance without a handshake.
                if (!cmd_valid || cmd_ready) begin
                    if (cmd_valid) open_n[idx] = 1'b0;
                    if (idx == 3'(NUM_BANKS - 1)) begin
                        state_n = S_IDLE;
                        valid_n = 1'b0;
                        out_n   = '0;
                        done_n  = 1'b1;
                    end else begin
                        idx_n   = nxt;
                        valid_n = open_q[nxt];
                        if (open_q[nxt]) out_n = mk_cmd(CMD_PRECHARGE, rows_q[nxt], '0, nxt);
                        else             out_n = '0;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                valid_n = 1'b0;
                out_n   = '0;
                tag_n   = 7'd0;
                last_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            idx        <= 3'd0;
            op_q       <= OP_READ;
            row_q      <= '0;
            col_q      <= '0;
            bank_q     <= 3'd0;
            open_q     <= '0;
            rows_q     <= '0;
            cmd_valid  <= 1'b0;
            cmd_out    <= '0;
            cmd_tag    <= 7'd0;
            cmd_last   <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            op_q       <= op_n;
            row_q      <= row_n;
            col_q      <= col_n;
            bank_q     <= bank_n;
            open_q     <= open_n;
            rows_q     <= rows_n;
            cmd_valid  <= valid_n;
            cmd_out    <= out_n;
            cmd_tag    <= tag_n;
            cmd_last   <= last_n;
            flush_done <= done_n;
        end
    end

endmodule

// File: tb/tb_frontend_request_translator.sv
// tb/tb_frontend_request_translator.sv - scoreboard bench for frontend_request_translator
`timescale 1ns/1ps
module tb_frontend_request_translator;
    import frontend_request_translator_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid = 1'b0;
    logic req_ready;
    frontend_interconnection_request_t req_in = '0;
    logic flush = 1'b0;
    logic flush_done;
    logic cmd_valid;
    logic cmd_ready = 1'b1;
    bank_command_t cmd_out;
    logic [6:0] cmd_tag;
    logic cmd_last;

    frontend_request_translator #(.NUM_BANKS(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_in(req_in), .flush(flush), .flush_done(flush_done), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_out(cmd_out), .cmd_tag(cmd_tag), .cmd_last(cmd_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bank_command_t cmd;
        logic [6:0]    tag;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int rdy_mode = 0;
    int flush_exp = 0;
    int flush_seen = 0;
    bit m_open[8];
    int m_row[8];

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(cmd_t c, int row, int col, int bank, logic [6:0] tag, logic last);
        exp_t e;
        e.cmd.cmd          = c;
        e.cmd.burst_length = BL_8;
        e.cmd.row_addr     = 14'(row);
        e.cmd.col_addr     = 14'(col);
        e.cmd.bank_addr    = 3'(bank);
        e.tag              = tag;
        e.last             = last;
        return e;
    endfunction

    // Open-page reference: what a request must cost given the bank's current row.
    task automatic model_req(op_type_t op, int row, int col, int bank, logic [6:0] tag);
        cmd_t cc = (op == OP_READ) ? CMD_READ : CMD_WRITE;
        if (!(m_open[bank] && m_row[bank] == row)) begin
            if (m_open[bank]) exp_q.push_back(mk(CMD_PRECHARGE, m_row[bank], 0, bank, tag, 1'b0));
            exp_q.push_back(mk(CMD_ACTIVE, row, 0, bank, tag, 1'b0));
        end
        exp_q.push_back(mk(cc, row, col, bank, tag, 1'b1));
        m_open[bank] = 1'b1;
        m_row[bank]  = row;
    endtask

    task automatic model_flush();
        for (int b = 0; b < 8; b++) begin
            if (m_open[b]) exp_q.push_back(mk(CMD_PRECHARGE, m_row[b], 0, b, 7'd0, 1'b0));
            m_open[b] = 1'b0;
        end
        flush_exp++;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: cmd_ready = 1'b1;
                1: cmd_ready = ($urandom_range(0, 3) != 0);
                default: cmd_ready = 1'b0;
            endcase
        end
    end

    initial begin
        bit pv = 1'b0;
        exp_t prev = '0;
        exp_t got;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
            end else begin
                got.cmd  = cmd_out;
                got.tag  = cmd_tag;
                got.last = cmd_last;
                if (pv) begin
                    check("stall_valid_hold", cmd_valid, 1);
                    check("stall_cmd_hold", got, prev);
                end
                if (cmd_valid) begin
                    if (cmd_ready) begin
                        if (exp_q.size() == 0) check("unexpected_cmd", got, 0);
                        else begin
                            e = exp_q.pop_front();
                            check("cmd", got, e);
                        end
                    end
                    pv   = !cmd_ready;
                    prev = got;
                end else begin
                    check("idle_outputs_zero", got, 0);
                    pv = 1'b0;
                end
                if (flush_done) flush_seen++;
            end
        end
    end

    task automatic drain();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || cmd_valid) && n < 500);
        if (n >= 500) check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic send_req(op_type_t op, int row, int col, int bank, int id, int core, bit toggle);
        int n = 0;
        @(negedge clk);
        req_in.op_type   = op;
        req_in.data_type = data_type_t'($urandom_range(0, 3));
        req_in.row_addr  = ROW_W'(row);
        req_in.col_addr  = COL_W'(col);
        req_in.bank_addr = 3'(bank);
        req_in.req_id    = 5'(id);
        req_in.core_num  = 2'(core);
        req_valid = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
            if (toggle) req_valid = 1'($urandom_range(0, 1));
        end
        if (n >= 300) begin
            check("req_ready_timeout", req_ready, 1);
            req_valid = 1'b0;
        end else begin
            req_valid = 1'b1;
            model_req(op, row, col, bank, {5'(id), 2'(core)});
            @(posedge clk);
            #1 req_valid = 1'b0;
        end
    endtask

    task automatic do_flush(bit chk_lat);
        int k = 0;
        drain();
        @(negedge clk);
        flush = 1'b1;
        model_flush();
        @(posedge clk);
        #1 flush = 1'b0;
        do begin
            @(negedge clk);
            k++;
        end while (!flush_done && k < 200);
        if (chk_lat) check("flush_done_cycle", k, 9);
        else         check("flush_done_seen", k < 200, 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        for (int b = 0; b < 8; b++) m_open[b] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            req_valid = 1'($urandom_range(0, 1));
            flush     = 1'($urandom_range(0, 1));
            req_in    = {$urandom, $urandom};
            check("rst_cmd_valid", cmd_valid, 0);
            check("rst_cmd_out", cmd_out, 0);
            check("rst_tag_last", {cmd_tag, cmd_last}, 0);
            check("rst_flush_done", flush_done, 0);
        end
        req_valid = 1'b0;
        flush     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("req_ready_after_reset", req_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        for (int b = 0; b < 8; b++) begin
            m_open[b] = 1'b0;
            m_row[b]  = 0;
        end
        do_reset();

        // Cold read, hit write, miss read on bank 2.
        send_req(OP_READ, 'h12, 'h8, 2, 3, 1, 1'b0);
        drain();
        send_req(OP_WRITE, 'h12, 'h10, 2, 3, 1, 1'b0);
        send_req(OP_READ, 'h40, 'h4, 2, 7, 2, 1'b0);
        drain();

        // Backpressure on ACTIVE.
        rdy_mode = 2;
        send_req(OP_READ, 'h33, 'h1, 4, 9, 0, 1'b0);
        k = 0;
        while (!cmd_valid && k < 20) begin @(negedge clk); k++; end
        check("bp_cmd_is_active", cmd_out.cmd, CMD_ACTIVE);
        repeat (3) begin
            check("bp_req_ready_low", req_ready, 0);
            @(negedge clk);
        end
        rdy_mode = 0;
        drain();

        // Reset in the middle of a request discards it and clears the table.
        rdy_mode = 2;
        send_req(OP_WRITE, 'h21, 'h2, 3, 1, 1, 1'b0);
        k = 0;
        while (!cmd_valid && k < 20) begin @(negedge clk); k++; end
        rdy_mode = 0;
        do_reset();
        send_req(OP_READ, 'h21, 'h3, 3, 2, 2, 1'b0);
        send_req(OP_READ, 'h40, 'h5, 2, 2, 3, 1'b0);
        drain();

        // Flush with banks 1 and 5 open.
        do_reset();
        send_req(OP_READ, 'h5, 'h1, 1, 4, 0, 1'b0);
        send_req(OP_WRITE, 'h7, 'h2, 5, 4, 1, 1'b0);
        do_flush(1'b1);
        send_req(OP_READ, 'h5, 'h6, 1, 6, 2, 1'b0);
        drain();

        // Flush and request together: flush wins, request accepted on done cycle.
        do_reset();
        send_req(OP_WRITE, 'h9, 'h3, 6, 8, 3, 1'b0);
        drain();
        @(negedge clk);
        flush = 1'b1;
        req_in.op_type   = OP_READ;
        req_in.row_addr  = ROW_W'('h9);
        req_in.col_addr  = COL_W'('h4);
        req_in.bank_addr = 3'd6;
        req_in.req_id    = 5'd10;
        req_in.core_num  = 2'd1;
        req_valid = 1'b1;
        #1 check("prio_req_ready_low", req_ready, 0);
        model_flush();
        @(posedge clk);
        #1 flush = 1'b0;
        k = 0;
        while (!req_ready && k < 200) begin @(negedge clk); k++; end
        check("prio_accept_cycle", k, 9);
        check("prio_accept_with_done", flush_done, 1);
        model_req(OP_READ, 'h9, 'h4, 6, {5'd10, 2'd1});
        @(posedge clk);
        #1 req_valid = 1'b0;
        drain();

        // Randomized traffic with backpressure and occasional flushes.
        rdy_mode = 1;
        repeat (300) begin
            if ($urandom_range(0, 9) == 0) do_flush(1'b0);
            else send_req(op_type_t'($urandom_range(0, 1)), $urandom_range(0, 3),
                          $urandom_range(0, (1 << COL_W) - 1), $urandom_range(0, 7),
                          $urandom_range(0, 31), $urandom_range(0, 3), 1'b1);
        end
        drain();
        rdy_mode = 0;
        do_flush(1'b1);
        drain();
        repeat (3) @(negedge clk);
        check("flush_done_count", flush_seen, flush_exp);
        check("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/frontend_request_translator.md
# frontend_request_translator

Converts tagged frontend requests (op type, data type, row/col/bank address, req_id, core_num) into the ordered bank-command stream (PRECHARGE / ACTIVE / READ / WRITE) consumed by the command scheduler. Sits directly upstream of the command scheduler and downstream of the interconnect arbiter. Keeps a per-bank open-row table for an open-page policy. DRAM timing is not enforced here; the scheduler owns all timing counters.

## Interface
- NUM_BANKS, 8, number of banks tracked; bank field is 3 bits
- ROW_W, `ROW_ADDR_BITS, request row width; zero-extended to 14 bits on output
- COL_W, `COL_ADDR_BITS, request column width; zero-extended to 14 bits on output
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted on the cycle where req_valid && req_ready
- req_in  in  frontend_interconnection_request_t  command plus tag {req_id, core_num}
- flush  in  1  level request to close all open rows, e.g. before refresh
- flush_done  out  1  one-cycle pulse when flush completes
- cmd_valid  out  1  cmd_out valid
- cmd_ready  in  1  scheduler accepts cmd_out on cmd_valid && cmd_ready
- cmd_out  out  bank_command_t (36 bits)  {cmd, burst_length, row_addr[13:0], col_addr[13:0], bank_addr[2:0]}
- cmd_tag  out  7  {req_id, core_num} of the owning request; 0 for flush commands
- cmd_last  out  1  high only on the column (READ/WRITE) command of a request

## Operation
- Open-row table: per bank, open bit plus row register. All banks closed at reset.
- States: IDLE, PRE, ACT, COL, FLUSH.
- IDLE: req_ready = !flush. Flush has priority over requests. If flush is high, go to FLUSH with bank index 0. Otherwise, on accept, latch the request and branch:
  - bank open and row hit -> COL
  - bank open and row miss -> PRE
  - bank closed -> ACT
- PRE: emit CMD_PRECHARGE with bank_addr and row_addr = the old open row, col = 0. On handshake, clear the open bit and go to ACT.
- ACT: emit CMD_ACTIVE with the new row, col = 0. On handshake, set the open bit, store the row, and go to COL.
- COL: emit CMD_READ if op_type = OP_READ, else CMD_WRITE, with row, col, bank. cmd_last = 1. On handshake, go to IDLE.
- FLUSH: scan bank index 0..NUM_BANKS-1, one index per cycle.
  - Open bank: emit CMD_PRECHARGE for that bank and row. Hold until handshake, then clear the bank and advance.
  - Closed bank: skip it in that cycle with no cmd_valid.
  - After the last index: pulse flush_done for 1 cycle and return to IDLE. flush is sampled only in IDLE.
- burst_length is always BL_8. data_type is ignored.
- cmd_out is CMD_NOP with all fields zero whenever cmd_valid = 0.
- cmd_valid is never withdrawn, and cmd_out/cmd_tag/cmd_last never change, while cmd_valid && !cmd_ready.
- Address widths: row/col zero-extended to 14 bits; bank passes through at 3 bits.

## Timing
- Reset (asynchronous assert) gives: state IDLE, table cleared, cmd_valid = 0, cmd_out = NOP/zero, cmd_tag = 0, cmd_last = 0, flush_done = 0.
- req_ready is combinational from state and flush, so it is 1 out of reset when flush = 0.
- Reset mid-request: the request is discarded with no further commands, and the table is cleared.
- All outputs except req_ready are registered. First command is valid the cycle after accept.
- Cycles per request with cmd_ready tied high:
  - hit: 2 (accept + COL)
  - closed bank: 3
  - miss: 4
- Each emitting state adds one cycle per cycle of cmd_ready low.
- Flush takes NUM_BANKS cycles + 1 (done pulse) + backpressure stalls. With no open banks: 8 idle scan cycles, then flush_done.
- req_valid may toggle freely while req_ready = 0. No request is lost or duplicated.

## Test plan
- Reset: hold rst_n low with random inputs -> cmd_valid = 0, cmd_out = 0, flush_done = 0. After release with flush = 0 -> req_ready = 1.
- Cold read: bank 2, row 0x12, col 0x8, tag {5'd3, 2'd1}, cmd_ready = 1 -> ACTIVE(b2, r0x12), then READ(b2, r0x12, c0x8, cmd_last = 1), both with cmd_tag 0x0D.
- Row hit then miss:
  - WRITE to b2 r0x12 c0x10 -> single WRITE.
  - Then READ to b2 r0x40 -> PRECHARGE(b2, r0x12), ACTIVE(b2, r0x40), READ.
- Backpressure: cmd_ready low for 3 cycles during ACTIVE -> cmd_out held stable, req_ready = 0, then the sequence continues unchanged.
- Flush: banks 1 (r0x5) and 5 (r0x7) open, flush pulsed high -> PRECHARGE b1, PRECHARGE b5, flush_done pulse on cycle 10 (no stalls). A following request to b1 starts with ACTIVE.
- Flush priority: flush and req_valid asserted together in IDLE -> flush sequence runs first; the request is accepted in the first IDLE cycle with flush low.
